// File: rtl/ex_mem_buf_if.sv
// ---------------------------------------------------------------------------
// ex_mem_buf_if
// Purpose : Bundles the EX-side push channel, the MEM-side pop channel and
//           the occupancy status of the EX/MEM skid buffer.
// Modports: slave  - the buffer itself (consumes ex_*, produces mem_*/occ_o)
//           master - the environment around it (produces ex_*, mem_ready_i)
// Signals : ex_valid_i/ex_ready_o      push handshake
//           ex_wd_i/ex_wreg_i/ex_wdata_i  pushed entry fields
//           mem_valid_o/mem_ready_i    pop handshake
//           mem_wd_o/mem_wreg_o/mem_wdata_o  head entry fields
//           occ_o                      occupancy 0..2
// Option  : EX_MEM_HILO_EN adds the hi/lo write fields on both sides.
// ---------------------------------------------------------------------------
interface ex_mem_buf_if;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  occ_o;
`ifdef EX_MEM_HILO_EN
    logic        ex_whilo_i;
    logic [31:0] ex_hi_i;
    logic [31:0] ex_lo_i;
    logic        mem_whilo_o;
    logic [31:0] mem_hi_o;
    logic [31:0] mem_lo_o;
`endif

    modport slave (
        input  ex_valid_i, ex_wd_i, ex_wreg_i, ex_wdata_i, mem_ready_i,
        output ex_ready_o, mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o, occ_o
`ifdef EX_MEM_HILO_EN
        , input  ex_whilo_i, ex_hi_i, ex_lo_i
        , output mem_whilo_o, mem_hi_o, mem_lo_o
`endif
    );

    modport master (
        output ex_valid_i, ex_wd_i, ex_wreg_i, ex_wdata_i, mem_ready_i,
        input  ex_ready_o, mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o, occ_o
`ifdef EX_MEM_HILO_EN
        , output ex_whilo_i, ex_hi_i, ex_lo_i
        , input  mem_whilo_o, mem_hi_o, mem_lo_o
`endif
    );
endinterface

// File: rtl/ex_mem_buf.sv
// ---------------------------------------------------------------------------
// ex_mem_buf
// Purpose : Two-entry in-order skid buffer between the EX and MEM stages.
//           A main (head) register feeds MEM; a skid register absorbs one
//           extra result so that ex_ready_o can be a plain flop.
// Ports   : clk   - rising-edge clock
//           rst   - synchronous active-high reset (beats flush/push/pop)
//           flush - discards every buffered entry and any concurrent push
//           bus   - ex_mem_buf_if.slave: push channel, pop channel, occ_o
// Option  : define EX_MEM_HILO_EN to carry whilo/hi/lo alongside each entry.
// ---------------------------------------------------------------------------
module ex_mem_buf (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_mem_buf_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
`ifdef EX_MEM_HILO_EN
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   ex_ready_q, ex_ready_d;
    entry_t in_e;
    entry_t head;
    logic   push, pop;

    always_comb begin
        in_e       = '0;
        in_e.wd    = bus.ex_wd_i;
        in_e.wreg  = bus.ex_wreg_i;
        in_e.wdata = bus.ex_wdata_i;
`ifdef EX_MEM_HILO_EN
        in_e.whilo = bus.ex_whilo_i;
        in_e.hi    = bus.ex_hi_i;
        in_e.lo    = bus.ex_lo_i;
`endif
    end

    // ex_valid_i is only honoured while the registered ready is high.
    assign push = bus.ex_valid_i & ex_ready_q;
    assign pop  = (state_q != EMPTY) & bus.mem_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_e;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = FULL;
                        skid_d  = in_e;
                    end else if (push && pop) begin
                        main_d  = in_e;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        // Ready is registered from the next state, so it drops in the same
        // cycle the buffer becomes FULL and a push in FULL cannot happen.
        ex_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    // Bubbles present all-zero fields so MEM never writes on an empty slot.
    assign head = (state_q != EMPTY) ? main_q : '0;

    assign bus.ex_ready_o  = ex_ready_q;
    assign bus.mem_valid_o = (state_q != EMPTY);
    assign bus.mem_wd_o    = head.wd;
    assign bus.mem_wreg_o  = head.wreg;
    assign bus.mem_wdata_o = head.wdata;
    assign bus.occ_o       = state_q;
`ifdef EX_MEM_HILO_EN
    assign bus.mem_whilo_o = head.whilo;
    assign bus.mem_hi_o    = head.hi;
    assign bus.mem_lo_o    = head.lo;
`endif

endmodule
